// File: rtl/vit_pkg.sv
// Shared constants and types for the (2,1,3) channel model: code geometry,
// error-model mode encodings, LFSR taps and the burst state machine states.
package vit_pkg;

  localparam int N         = 2;
  localparam int BLOCK_LEN = 20;
  localparam int LFSR_W    = 16;
  localparam int GUARD_LEN = 8;

  localparam logic [1:0] MODE_PASS   = 2'd0;
  localparam logic [1:0] MODE_FIXED  = 2'd1;
  localparam logic [1:0] MODE_RANDOM = 2'd2;
  localparam logic [1:0] MODE_BURST  = 2'd3;

  // x^16 + x^14 + x^13 + x^11 + 1 expressed as feedback taps on bits 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GUARD = 2'd2
  } burst_state_t;

endpackage

// File: rtl/vit_lfsr.sv
// Fibonacci LFSR shifting left; the feedback bit is the XOR of the tapped bits.
// A zero seed would lock the register up, so it is replaced by 1.
module vit_lfsr #(
  parameter int             W    = 16,
  parameter logic [W-1:0]   SEED = 16'hACE1,
  parameter logic [W-1:0]   TAPS = 16'hB400
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         advance,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] INIT = (SEED == '0) ? W'(1) : SEED;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      value <= INIT;
    end else if (advance) begin
      value <= {value[W-2:0], ^(value & TAPS)};
    end
  end

endmodule

// File: rtl/vit_channel_213.sv
// Channel error injector between the convolutional encoder and the Viterbi decoder:
// flips code bits by a selectable error model and counts every bit it flips.
module vit_channel_213
  import vit_pkg::*;
#(
  parameter int                N         = vit_pkg::N,
  parameter int                BLOCK_LEN = vit_pkg::BLOCK_LEN,
  parameter int                LFSR_W    = vit_pkg::LFSR_W,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                GUARD_LEN = vit_pkg::GUARD_LEN
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] vx_in,
  input  logic         vx_valid,
  input  logic [1:0]   mode,
  input  logic [7:0]   err_thresh,
  input  logic [4:0]   pat_pos,
  input  logic [3:0]   burst_len,
  input  logic [3:0]   max_err,
  output logic [N-1:0] rx_out,
  output logic         rx_valid,
  output logic [N-1:0] err_mask,
  output logic [15:0]  err_count,
  output logic [4:0]   blk_pos
);

  burst_state_t        state, state_n;
  logic [3:0]          bcnt, bcnt_n;
  logic [7:0]          gcnt, gcnt_n;
  logic [4:0]          pos;
  logic [4:0]          blk_err, blk_err_eff;
  logic [LFSR_W-1:0]   lfsr;
  logic [N-1:0]        cand, mask_n;
  logic [3:0]          blen;
  logic [7:0]          flips;
  logic [16:0]         count_sum;

  vit_lfsr #(
    .W    (LFSR_W),
    .SEED (SEED),
    .TAPS (LFSR_W'(LFSR_TAPS))
  ) u_lfsr (
    .clock   (clock),
    .reset   (reset),
    .advance (vx_valid),
    .value   (lfsr)
  );

  // Candidate mask and burst FSM next state, both judged on the pre-advance LFSR value
  always_comb begin
    cand        = '0;
    state_n     = state;
    bcnt_n      = bcnt;
    gcnt_n      = gcnt;
    blen        = (burst_len == 4'd0) ? 4'd1 : burst_len;
    blk_err_eff = (pos == 5'd0) ? 5'd0 : blk_err;

    case (mode)
      MODE_FIXED: begin
        if (pos == pat_pos) cand = N'(1);
      end
      MODE_RANDOM: begin
        for (int i = 0; i < N; i++) begin
          cand[i] = (lfsr[8*i +: 8] < err_thresh);
        end
      end
      default: cand = '0;
    endcase

    if (mode != MODE_BURST) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (lfsr[7:0] < err_thresh) begin
            cand   = '1;
            bcnt_n = blen;
            if (blen == 4'd1) begin
              state_n = GUARD;
              gcnt_n  = 8'(GUARD_LEN);
            end else begin
              state_n = BURST;
            end
          end
        end
        BURST: begin
          cand   = '1;
          bcnt_n = bcnt - 4'd1;
          if (bcnt_n == 4'd1) begin
            state_n = GUARD;
            gcnt_n  = 8'(GUARD_LEN);
          end
        end
        GUARD: begin
          if (gcnt == 8'd1) state_n = IDLE;
          else              gcnt_n  = gcnt - 8'd1;
        end
        default: state_n = IDLE;
      endcase
    end

    mask_n = ((max_err != 4'd0) && (blk_err_eff == {1'b0, max_err})) ? '0 : cand;

    flips = '0;
    for (int i = 0; i < N; i++) begin
      flips = flips + 8'(mask_n[i]);
    end
    count_sum = {1'b0, err_count} + 17'(flips);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      bcnt      <= '0;
      gcnt      <= '0;
      pos       <= '0;
      blk_err   <= '0;
      rx_out    <= '0;
      rx_valid  <= 1'b0;
      err_mask  <= '0;
      err_count <= '0;
      blk_pos   <= '0;
    end else begin
      rx_valid <= vx_valid;
      if (vx_valid) begin
        state     <= state_n;
        bcnt      <= bcnt_n;
        gcnt      <= gcnt_n;
        pos       <= (pos == 5'(BLOCK_LEN - 1)) ? 5'd0 : pos + 5'd1;
        blk_err   <= blk_err_eff + 5'(mask_n != '0);
        rx_out    <= vx_in ^ mask_n;
        err_mask  <= mask_n;
        blk_pos   <= pos;
        // Saturate rather than wrap so the checker never sees a small count after overflow
        err_count <= count_sum[16] ? 16'hFFFF : count_sum[15:0];
      end
    end
  end

endmodule

// File: tb/tb_vit_channel_213.sv
// Directed bench for vit_channel_213: hand-derived expectations for the main
// scenarios plus a small behavioural channel model for LFSR-dependent symbols.
module tb_vit_channel_213;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  vx_in;
  logic        vx_valid;
  logic [1:0]  mode;
  logic [7:0]  err_thresh;
  logic [4:0]  pat_pos;
  logic [3:0]  burst_len;
  logic [3:0]  max_err;
  logic [1:0]  rx_out;
  logic        rx_valid;
  logic [1:0]  err_mask;
  logic [15:0] err_count;
  logic [4:0]  blk_pos;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_lfsr;
  int          m_pos, m_blk_err, m_state, m_burst_left, m_guard_left, m_count;
  logic [1:0]  m_rx, m_mask;
  logic [4:0]  m_blk_pos;
  logic        m_valid;

  vit_channel_213 dut (
    .clock      (clock),
    .reset      (reset),
    .vx_in      (vx_in),
    .vx_valid   (vx_valid),
    .mode       (mode),
    .err_thresh (err_thresh),
    .pat_pos    (pat_pos),
    .burst_len  (burst_len),
    .max_err    (max_err),
    .rx_out     (rx_out),
    .rx_valid   (rx_valid),
    .err_mask   (err_mask),
    .err_count  (err_count),
    .blk_pos    (blk_pos)
  );

  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lfsr = 16'hACE1;
    m_pos = 0; m_blk_err = 0; m_state = 0;
    m_burst_left = 0; m_guard_left = 0; m_count = 0;
    m_rx = 0; m_mask = 0; m_blk_pos = 0; m_valid = 0;
  endtask

  // Burst tracked as remaining errored / clean symbols (state 0 idle, 1 burst, 2 guard)
  task automatic model_step(input logic [1:0] vx, input logic valid);
    logic [1:0] cm;
    int         be;
    m_valid = valid;
    if (!valid) return;
    be = (m_pos == 0) ? 0 : m_blk_err;
    cm = 2'b00;
    if (mode == 2'd1 && m_pos == int'(pat_pos)) cm = 2'b01;
    if (mode == 2'd2) begin
      cm[0] = (m_lfsr[7:0]  < err_thresh);
      cm[1] = (m_lfsr[15:8] < err_thresh);
    end
    if (mode != 2'd3) begin
      m_state = 0;
    end else if (m_state == 0) begin
      if (m_lfsr[7:0] < err_thresh) begin
        cm = 2'b11;
        m_burst_left = ((burst_len == 0) ? 1 : int'(burst_len)) - 1;
        m_guard_left = 8;
        m_state = (m_burst_left > 0) ? 1 : 2;
      end
    end else if (m_state == 1) begin
      cm = 2'b11;
      m_burst_left--;
      if (m_burst_left == 0) m_state = 2;
    end else begin
      m_guard_left--;
      if (m_guard_left == 0) m_state = 0;
    end
    m_mask = (max_err != 0 && be == int'(max_err)) ? 2'b00 : cm;
    m_blk_err = be + ((m_mask != 0) ? 1 : 0);
    m_count = m_count + int'(m_mask[0]) + int'(m_mask[1]);
    if (m_count > 65535) m_count = 65535;
    m_rx = vx ^ m_mask;
    m_blk_pos = 5'(m_pos);
    m_pos = (m_pos == 19) ? 0 : m_pos + 1;
    m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  endtask

  task automatic check_all();
    check_output("rx_valid", rx_valid, m_valid);
    check_output("rx_out", rx_out, m_rx);
    check_output("err_mask", err_mask, m_mask);
    check_output("blk_pos", blk_pos, m_blk_pos);
    check_output("err_count", err_count, m_count);
  endtask

  task automatic apply_stimulus(input logic [1:0] vx, input logic valid, input bit full);
    vx_in = vx;
    vx_valid = valid;
    @(posedge clock);
    model_step(vx, valid);
    #1;
    if (full) check_all();
  endtask

  // Asserted between edges so the asynchronous clear is observed before any clock
  task automatic reset_pulse();
    vx_valid = 1'b0;
    reset = 1'b0;
    #2;
    check_output("rst_rx_out", rx_out, 0);
    check_output("rst_rx_valid", rx_valid, 0);
    check_output("rst_err_mask", err_mask, 0);
    check_output("rst_err_count", err_count, 0);
    check_output("rst_blk_pos", blk_pos, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    vx_in = 0; vx_valid = 0; mode = 0; err_thresh = 0;
    pat_pos = 0; burst_len = 0; max_err = 0;
    model_reset();
    @(posedge clock);
    @(posedge clock);
    #1;
    check_output("init_rx_valid", rx_valid, 0);
    check_output("init_err_count", err_count, 0);
    check_output("init_blk_pos", blk_pos, 0);
    reset = 1'b1;

    // T1: pass-through with idle gaps
    mode = 2'd0;
    for (int i = 0; i < 200; i++) begin
      apply_stimulus(2'($urandom), (i % 7) != 6, 1'b1);
    end
    check_output("t1_err_count", err_count, 0);

    // T2: fixed single-bit error at position 3 over three blocks
    reset_pulse();
    mode = 2'd1; pat_pos = 5'd3; max_err = 4'd0;
    for (int i = 0; i < 60; i++) begin
      apply_stimulus(2'($urandom), 1'b1, 1'b1);
      check_output("t2_mask", err_mask, ((i % 20) == 3) ? 2'b01 : 2'b00);
    end
    check_output("t2_err_count", err_count, 3);

    // T3: every bit wants to flip but only two symbols per block are allowed
    reset_pulse();
    mode = 2'd2; err_thresh = 8'd255; max_err = 4'd2;
    for (int i = 0; i < 20; i++) begin
      apply_stimulus(2'b10, 1'b1, 1'b1);
      check_output("t3_mask", err_mask, (i < 2) ? 2'b11 : 2'b00);
    end
    check_output("t3_err_count", err_count, 4);

    // T4: 3-symbol bursts followed by an 8-symbol guard, then 1-symbol bursts
    reset_pulse();
    mode = 2'd3; err_thresh = 8'd255; burst_len = 4'd3; max_err = 4'd0;
    for (int i = 0; i < 31; i++) begin
      apply_stimulus(2'b01, 1'b1, 1'b1);
      if (i < 11) check_output("t4_mask", err_mask, (i < 3) ? 2'b11 : 2'b00);
    end
    burst_len = 4'd0;
    for (int i = 0; i < 30; i++) begin
      apply_stimulus(2'($urandom), 1'b1, 1'b1);
    end
    max_err = 4'd1;
    for (int i = 0; i < 25; i++) begin
      apply_stimulus(2'($urandom), 1'b1, 1'b1);
    end

    // T5: reset in the middle of a block restarts position and LFSR
    reset_pulse();
    mode = 2'd2; err_thresh = 8'd255; max_err = 4'd3;
    for (int i = 0; i < 7; i++) begin
      apply_stimulus(2'($urandom), 1'b1, 1'b1);
    end
    check_output("t5_pre_count", err_count, 6);
    reset_pulse();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(2'b00, 1'b1, 1'b1);
      check_output("t5_mask", err_mask, 2'b11);
      check_output("t5_blk_pos", blk_pos, i);
    end

    // T6: run the counter into saturation and make sure it stays there
    reset_pulse();
    mode = 2'd2; err_thresh = 8'd255; max_err = 4'd0;
    for (int i = 0; i < 40000 && m_count < 65535; i++) begin
      apply_stimulus(2'($urandom), 1'b1, (i % 2048 == 0) || (m_count >= 65528));
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(2'($urandom), 1'b1, 1'b1);
    end
    check_output("t6_saturated", err_count, 16'hFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
